// File: rtl/prco_debug_uart_tx_if.sv
// Debug byte channel from prco_core to the debug UART transmitter.
//   i_dbg_data : debug byte (core q_debug)
//   i_dbg_we   : write strobe, one byte per cycle high
//   q_stall    : transmitter FIFO full; the core holds its pipeline while high
// Handshake: a byte transfers on every rising clk edge where i_dbg_we is high
// and q_stall is low. A write while q_stall is high is dropped, and the
// transmitter records the drop.
interface prco_debug_uart_tx_if;
  logic [7:0] i_dbg_data;
  logic       i_dbg_we;
  logic       q_stall;

  modport master (output i_dbg_data, output i_dbg_we, input q_stall);
  modport slave  (input i_dbg_data, input i_dbg_we, output q_stall);
endinterface

// File: rtl/prco_debug_uart_tx.sv
// Debug UART transmitter: buffers debug bytes from prco_core in a circular
// FIFO and sends them as UART 8N1 (idle high, start low, 8 data bits LSB
// first, stop high). The FIFO-full flag stalls the core so no byte is lost.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_en           : allows new frames to start; a running frame always finishes
//   dbg            : debug byte channel (data, write strobe, stall)
//   q_tx           : UART serial output, idle high
//   q_busy         : FSM not idle or FIFO not empty
//   q_fifo_count   : FIFO occupancy, 0..2**FIFO_DEPTH_LOG2
//   q_overflow     : sticky, set when a write is dropped because the FIFO is full
//   q_state        : current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module prco_debug_uart_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en,
  prco_debug_uart_tx_if.slave      dbg,
  output logic                     q_tx,
  output logic                     q_busy,
  output logic [FIFO_DEPTH_LOG2:0] q_fifo_count,
  output logic                     q_overflow,
  output logic [1:0]               q_state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // FIFO storage and pointers
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr;
  logic [FIFO_DEPTH_LOG2-1:0] rptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic [FIFO_DEPTH_LOG2:0]   count_next;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;

  // Serialiser state
  tx_state_e        state;
  tx_state_e        state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shreg;
  logic [7:0]       shreg_next;
  logic             tx_next;
  logic             busy_next;
  logic             en_q;

  // Fullness comes from the registered count, so a write in a full cycle is
  // dropped even when the serialiser pops in that same cycle.
  assign full        = (count == COUNT_FULL);
  assign empty       = (count == '0);
  assign push        = dbg.i_dbg_we && !full;
  assign dbg.q_stall = full;

  assign q_fifo_count = count;
  assign q_state      = state;

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr] <= dbg.i_dbg_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      q_overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (dbg.i_dbg_we && full) begin
        q_overflow <= 1'b1;
      end
    end
  end

  // Next state and next registered outputs. q_tx is registered from the
  // value the line must carry in the state being entered, so the line
  // changes on the same edge as the state.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    tx_next       = 1'b1;
    pop           = 1'b0;

    unique case (state)
      IDLE: begin
        if (en_q && !empty) begin
          pop           = 1'b1;
          shreg_next    = mem[rptr];
          state_next    = START;
          baud_cnt_next = '0;
          tx_next       = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
          tx_next       = shreg[0];
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_next = shreg[0];
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            // Shift right so the bit on the line is always shreg[0].
            bit_idx_next = bit_idx + 1'b1;
            shreg_next   = {1'b0, shreg[7:1]};
            tx_next      = shreg[1];
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_cnt == CNT_LAST) begin
          baud_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
      end
    endcase

    busy_next = (state_next != IDLE) || (count_next != '0);
  end

  // i_en passes through one register, so a queued byte starts two cycles
  // after i_en rises.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      q_tx     <= 1'b1;
      q_busy   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      q_tx     <= tx_next;
      q_busy   <= busy_next;
      en_q     <= i_en;
    end
  end

endmodule

// File: tb/tb_prco_debug_uart_tx.sv
module tb_prco_debug_uart_tx;
  localparam int CPB = 4;
  localparam int FL2 = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  prco_debug_uart_tx_if dbg_if ();

  logic           q_tx;
  logic           q_busy;
  logic [FL2:0]   q_fifo_count;
  logic           q_overflow;
  logic [1:0]     q_state;

  prco_debug_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(FL2)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .dbg          (dbg_if),
    .q_tx         (q_tx),
    .q_busy       (q_busy),
    .q_fifo_count (q_fifo_count),
    .q_overflow   (q_overflow),
    .q_state      (q_state)
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         mon_active = 1'b0;
  int         mon_idx = 0;
  logic [7:0] rx_byte;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((q_busy || mon_active) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, q_busy}, 32'd0);
  endtask

  // UART receiver: samples each bit in its middle, aborts on reset.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (q_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_idx    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_idx++;
      if (mon_idx == 2) begin
        chk("rx_start_bit", {31'd0, q_tx}, 32'd0);
      end else if (mon_idx >= 6 && mon_idx <= 34 && ((mon_idx - 6) % 4) == 0) begin
        rx_byte[(mon_idx - 6) / 4] = q_tx;
      end else if (mon_idx == 38) begin
        chk("rx_stop_bit", {31'd0, q_tx}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_byte", {24'd0, rx_byte}, 32'hffff_ffff);
        end else begin
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int low_seen;
    dbg_if.i_dbg_we   = 1'b0;
    dbg_if.i_dbg_data = 8'h00;

    // 1. reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_tx",       {31'd0, q_tx},         32'd1);
    chk("rst_stall",    {31'd0, dbg_if.q_stall}, 32'd0);
    chk("rst_count",    {28'd0, q_fifo_count}, 32'd0);
    chk("rst_overflow", {31'd0, q_overflow},   32'd0);
    chk("rst_busy",     {31'd0, q_busy},       32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // 2. single byte 0xA5
    exp_q.push_back(8'hA5);
    dbg_if.i_dbg_data = 8'hA5;
    dbg_if.i_dbg_we   = 1'b1;
    tick();                                   // N+1
    dbg_if.i_dbg_we   = 1'b0;
    chk("t2_count_n1", {28'd0, q_fifo_count}, 32'd1);
    chk("t2_tx_n1",    {31'd0, q_tx},         32'd1);
    tick();                                   // N+2
    chk("t2_tx_fall_n2", {31'd0, q_tx}, 32'd0);
    k = 2;
    while (q_busy && k < 100) begin
      tick();
      k++;
    end
    chk("t2_busy_fall_cycle", k, 32'd42);

    // 3. ten consecutive writes into an 8-deep FIFO
    start_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 10; i++) begin
      dbg_if.i_dbg_data = 8'(i);
      dbg_if.i_dbg_we   = 1'b1;
      tick();
      if (i == 7) chk("t3_stall_before_last", {31'd0, dbg_if.q_stall}, 32'd0);
      if (i == 8) begin
        chk("t3_stall_after_08", {31'd0, dbg_if.q_stall}, 32'd1);
        chk("t3_count_full",     {28'd0, q_fifo_count},   32'd8);
        chk("t3_no_overflow_yet", {31'd0, q_overflow},    32'd0);
      end
    end
    dbg_if.i_dbg_we = 1'b0;
    chk("t3_overflow", {31'd0, q_overflow},   32'd1);
    chk("t3_count",    {28'd0, q_fifo_count}, 32'd8);
    wait_idle("t3_drain", 600);
    chk("t3_frames", start_q.size(), 32'd9);
    for (int i = 1; i < start_q.size(); i++) begin
      chk("t3_frame_gap", start_q[i] - start_q[i-1], 32'd41);
    end

    // 4. write rejected in the same cycle as a pop from a full FIFO
    en = 1'b0;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      dbg_if.i_dbg_data = 8'h10 + 8'(i);
      dbg_if.i_dbg_we   = 1'b1;
      tick();
    end
    dbg_if.i_dbg_we = 1'b0;
    chk("t4_count_full", {28'd0, q_fifo_count},   32'd8);
    chk("t4_stall",      {31'd0, dbg_if.q_stall}, 32'd1);
    en = 1'b1;                                // cycle M
    tick();                                   // M+1: pop happens at the end of this cycle
    dbg_if.i_dbg_data = 8'h99;
    dbg_if.i_dbg_we   = 1'b1;
    tick();                                   // M+2
    dbg_if.i_dbg_we   = 1'b0;
    chk("t4_count_after_pop", {28'd0, q_fifo_count}, 32'd7);
    chk("t4_overflow",        {31'd0, q_overflow},   32'd1);
    chk("t4_tx_start",        {31'd0, q_tx},         32'd0);
    wait_idle("t4_drain", 600);

    // 5. i_en dropped mid-frame
    do_reset(2);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h5A);
    dbg_if.i_dbg_data = 8'h3C;
    dbg_if.i_dbg_we   = 1'b1;
    tick();                                   // N+1
    dbg_if.i_dbg_data = 8'h5A;
    tick();                                   // N+2
    dbg_if.i_dbg_we   = 1'b0;
    chk("t5_tx_start", {31'd0, q_tx}, 32'd0);
    repeat (8) tick();                        // N+10
    en = 1'b0;
    low_seen = 0;
    for (int c = 11; c <= 60; c++) begin
      tick();
      if (c >= 43 && q_tx !== 1'b1) low_seen++;
    end
    chk("t5_no_start_while_disabled", low_seen, 32'd0);
    chk("t5_state_idle", {30'd0, q_state},      32'd0);
    chk("t5_count",      {28'd0, q_fifo_count}, 32'd1);
    en = 1'b1;                                // cycle R
    tick();
    chk("t5_tx_r1", {31'd0, q_tx}, 32'd1);
    tick();
    chk("t5_tx_r2", {31'd0, q_tx}, 32'd0);
    wait_idle("t5_drain", 200);

    // 6. reset during DATA bit 3 with 4 bytes queued
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      dbg_if.i_dbg_data = 8'h61 + 8'(i);
      dbg_if.i_dbg_we   = 1'b1;
      tick();
    end
    dbg_if.i_dbg_we = 1'b0;                   // N+5
    repeat (14) tick();                       // N+19, DATA bit 3
    chk("t6_state_data",  {30'd0, q_state},      32'd2);
    chk("t6_count_queued", {28'd0, q_fifo_count}, 32'd4);
    rst = 1'b1;
    tick();
    chk("t6_tx",       {31'd0, q_tx},         32'd1);
    chk("t6_count",    {28'd0, q_fifo_count}, 32'd0);
    chk("t6_overflow", {31'd0, q_overflow},   32'd0);
    chk("t6_busy",     {31'd0, q_busy},       32'd0);
    rst = 1'b0;
    low_seen = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (q_tx !== 1'b1) low_seen++;
    end
    chk("t6_no_frames", low_seen, 32'd0);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
